// File: rtl/ex_stage_if.sv
// Bundle and handshake signals between the execute stage and its neighbours
// (decode, memory stage, data SRAM). The slave modport is the EX stage side.
interface ex_stage_if;
    logic         ex_allowin;
    logic [151:0] id_to_ex_wire;
    logic         id_to_ex_valid;
    logic         mem_allowin;
    logic [103:0] ex_to_mem_wire;
    logic         ex_to_mem_valid;
    logic         data_sram_en;
    logic [3:0]   data_sram_we;
    logic [31:0]  data_sram_addr;
    logic [31:0]  data_sram_wdata;
    logic [38:0]  ex_rf_zip;

    modport master (
        input  ex_allowin,
        output id_to_ex_wire,
        output id_to_ex_valid,
        output mem_allowin,
        input  ex_to_mem_wire,
        input  ex_to_mem_valid,
        input  data_sram_en,
        input  data_sram_we,
        input  data_sram_addr,
        input  data_sram_wdata,
        input  ex_rf_zip
    );

    modport slave (
        output ex_allowin,
        input  id_to_ex_wire,
        input  id_to_ex_valid,
        input  mem_allowin,
        output ex_to_mem_wire,
        output ex_to_mem_valid,
        output data_sram_en,
        output data_sram_we,
        output data_sram_addr,
        output data_sram_wdata,
        output ex_rf_zip
    );
endinterface

// File: rtl/ex_stage.sv
// Execute stage: latches the decode bundle, computes the ALU result, issues the
// data SRAM request and exports the forwarding/stall bundle to decode.
// Define EX_DIV_EN to build the 32-step restoring divider for
// div.w / mod.w / div.wu / mod.wu; without it div_op is ignored.

// Single-cycle ALU, one-hot operation select:
// [0] add [1] sub [2] slt [3] sltu [4] and [5] nor [6] or [7] xor
// [8] sll [9] srl [10] sra [11] lui (passes src2)
module alu (
    input  logic [11:0] alu_op_i,
    input  logic [31:0] alu_src1_i,
    input  logic [31:0] alu_src2_i,
    output logic [31:0] alu_result_o
);
    logic [4:0] shamt;
    assign shamt = alu_src2_i[4:0];

    // OR together the masked result of every selected operation
    always_comb begin
        alu_result_o = '0;
        if (alu_op_i[0])  alu_result_o = alu_result_o | (alu_src1_i + alu_src2_i);
        if (alu_op_i[1])  alu_result_o = alu_result_o | (alu_src1_i - alu_src2_i);
        if (alu_op_i[2])  alu_result_o = alu_result_o | {31'b0, $signed(alu_src1_i) < $signed(alu_src2_i)};
        if (alu_op_i[3])  alu_result_o = alu_result_o | {31'b0, alu_src1_i < alu_src2_i};
        if (alu_op_i[4])  alu_result_o = alu_result_o | (alu_src1_i & alu_src2_i);
        if (alu_op_i[5])  alu_result_o = alu_result_o | ~(alu_src1_i | alu_src2_i);
        if (alu_op_i[6])  alu_result_o = alu_result_o | (alu_src1_i | alu_src2_i);
        if (alu_op_i[7])  alu_result_o = alu_result_o | (alu_src1_i ^ alu_src2_i);
        if (alu_op_i[8])  alu_result_o = alu_result_o | (alu_src1_i << shamt);
        if (alu_op_i[9])  alu_result_o = alu_result_o | (alu_src1_i >> shamt);
        if (alu_op_i[10]) alu_result_o = alu_result_o | 32'($signed(alu_src1_i) >>> shamt);
        if (alu_op_i[11]) alu_result_o = alu_result_o | alu_src2_i;
    end
endmodule

module ex_stage (
    input  logic      clk,
    input  logic      resetn,
    ex_stage_if.slave ex_bus
);
    logic         ex_valid_q;
    logic [151:0] id_bundle_q;

    logic [11:0]  alu_op;
    logic [31:0]  alu_src1;
    logic [31:0]  alu_src2;
    logic [3:0]   div_op;
    logic         rf_we;
    logic [4:0]   rf_waddr;
    logic [31:0]  pc;
    logic [31:0]  rkd_value;
    logic         res_from_mem;
    logic         mem_we;

    logic         ex_allowin;
    logic         ex_ready_go;
    logic         stall_req;
    logic         sram_en;
    logic [31:0]  alu_result;
    logic [31:0]  ex_result;

    assign {alu_op, alu_src1, alu_src2, div_op, rf_we, rf_waddr, pc,
            rkd_value, res_from_mem, mem_we} = id_bundle_q;

    // Stage valid bit: refilled from decode whenever the stage can accept
    always_ff @(posedge clk) begin
        if (!resetn) begin
            ex_valid_q <= 1'b0;
        end else if (ex_allowin) begin
            ex_valid_q <= ex_bus.id_to_ex_valid;
        end
    end

    // Payload register: captures the decode bundle only on an accepted handshake
    always_ff @(posedge clk) begin
        if (!resetn) begin
            id_bundle_q <= '0;
        end else if (ex_bus.id_to_ex_valid && ex_allowin) begin
            id_bundle_q <= ex_bus.id_to_ex_wire;
        end
    end

    alu u_alu (
        .alu_op_i     (alu_op),
        .alu_src1_i   (alu_src1),
        .alu_src2_i   (alu_src2),
        .alu_result_o (alu_result)
    );

`ifdef EX_DIV_EN
    typedef enum logic [1:0] {DIV_IDLE, DIV_RUN, DIV_DONE} div_state_e;

    div_state_e  div_state_q, div_state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] dvs_q, dvs_d;

    logic        is_div;
    logic        div_signed;
    logic        div_want_rem;
    logic [31:0] abs_src1;
    logic [31:0] abs_src2;
    logic [32:0] trial;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;

    // div_op one-hot: [3] div.w [2] mod.w [1] div.wu [0] mod.wu
    assign is_div       = |div_op;
    assign div_signed   = div_op[3] | div_op[2];
    assign div_want_rem = div_op[2] | div_op[0];
    assign abs_src1     = (div_signed && alu_src1[31]) ? -alu_src1 : alu_src1;
    assign abs_src2     = (div_signed && alu_src2[31]) ? -alu_src2 : alu_src2;

    // Partial remainder stays below the divisor, so the shifted value fits in
    // 33 bits and bit 32 of the difference is the borrow. A zero divisor
    // always succeeds, giving an all-ones quotient and remainder = dividend.
    assign trial = {rem_q, quo_q[31]} - {1'b0, dvs_q};

    assign quo_fix   = (div_signed && (alu_src1[31] ^ alu_src2[31])) ? -quo_q : quo_q;
    assign rem_fix   = (div_signed && alu_src1[31]) ? -rem_q : rem_q;
    assign ex_result = is_div ? (div_want_rem ? rem_fix : quo_fix) : alu_result;

    assign ex_ready_go = ~is_div | (div_state_q == DIV_DONE);
    assign stall_req   = ex_valid_q & (res_from_mem | (is_div & (div_state_q != DIV_DONE)));

    // Divider state and datapath registers
    always_ff @(posedge clk) begin
        if (!resetn) begin
            div_state_q <= DIV_IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
        end else begin
            div_state_q <= div_state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvs_q       <= dvs_d;
        end
    end

    // Divider next state: load operands, one restoring step per RUN cycle
    always_comb begin
        div_state_d = div_state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvs_d       = dvs_q;
        case (div_state_q)
            DIV_IDLE: begin
                if (ex_valid_q && is_div) begin
                    div_state_d = DIV_RUN;
                    cnt_d       = '0;
                    rem_d       = '0;
                    quo_d       = abs_src1;
                    dvs_d       = abs_src2;
                end
            end
            DIV_RUN: begin
                if (!trial[32]) begin
                    rem_d = trial[31:0];
                    quo_d = {quo_q[30:0], 1'b1};
                end else begin
                    rem_d = {rem_q[30:0], quo_q[31]};
                    quo_d = {quo_q[30:0], 1'b0};
                end
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'd31) begin
                    div_state_d = DIV_DONE;
                end
            end
            DIV_DONE: begin
                if (ex_bus.mem_allowin) begin
                    div_state_d = DIV_IDLE;
                end
            end
            default: div_state_d = DIV_IDLE;
        endcase
    end
`else
    logic unused_div_op;

    assign unused_div_op = ^div_op;
    assign ex_result     = alu_result;
    assign ex_ready_go   = 1'b1;
    assign stall_req     = ex_valid_q & res_from_mem;
`endif

    assign ex_allowin = ~ex_valid_q | (ex_ready_go & ex_bus.mem_allowin);
    assign sram_en    = ex_valid_q & ex_ready_go & ex_bus.mem_allowin & (res_from_mem | mem_we);

    assign ex_bus.ex_allowin      = ex_allowin;
    assign ex_bus.ex_to_mem_valid = ex_valid_q & ex_ready_go;
    assign ex_bus.ex_to_mem_wire  = {rf_we, rf_waddr, pc, ex_result, rkd_value, res_from_mem, mem_we};
    assign ex_bus.data_sram_en    = sram_en;
    assign ex_bus.data_sram_we    = {4{mem_we & sram_en}};
    assign ex_bus.data_sram_addr  = ex_result;
    assign ex_bus.data_sram_wdata = rkd_value;
    assign ex_bus.ex_rf_zip       = {stall_req, rf_we & ex_valid_q, rf_waddr, ex_result};
endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed cases plus randomized
// instructions compared against an arithmetic reference model.
// Divider expectations follow EX_DIV_EN.
module tb_ex_stage;
    logic clk = 1'b0;
    logic resetn;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

`ifdef EX_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    ex_stage_if bus ();

    ex_stage dut (
        .clk    (clk),
        .resetn (resetn),
        .ex_bus (bus)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference ALU: one-hot select, plain arithmetic
    function automatic logic [31:0] alu_ref(input logic [11:0] op, input logic [31:0] a, input logic [31:0] b);
        int unsigned sh;
        sh = b % 32;
        for (int k = 0; k < 12; k++) begin
            if (op[k]) begin
                case (k)
                    0:  return a + b;
                    1:  return a - b;
                    2:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    3:  return (a < b) ? 32'd1 : 32'd0;
                    4:  return a & b;
                    5:  return ~(a | b);
                    6:  return a | b;
                    7:  return a ^ b;
                    8:  return a << sh;
                    9:  return a >> sh;
                    10: return $signed(a) >>> sh;
                    default: return b;
                endcase
            end
        end
        return 32'd0;
    endfunction

    // Reference divider: magnitudes with / and %, then sign fixup
    function automatic logic [31:0] div_ref(input logic [3:0] dop, input logic [31:0] a, input logic [31:0] b);
        logic        sgn;
        logic [31:0] ua, ub, q, r;
        sgn = dop[3] | dop[2];
        ua  = (sgn && a[31]) ? 32'd0 - a : a;
        ub  = (sgn && b[31]) ? 32'd0 - b : b;
        if (ub == 0) begin
            q = 32'hFFFF_FFFF;
            r = ua;
        end else begin
            q = ua / ub;
            r = ua % ub;
        end
        if (sgn && (a[31] != b[31])) q = 32'd0 - q;
        if (sgn && a[31]) r = 32'd0 - r;
        return (dop[2] | dop[0]) ? r : q;
    endfunction

    function automatic logic [31:0] exp_result(input logic [11:0] aop, input logic [3:0] dop,
                                               input logic [31:0] a, input logic [31:0] b);
        if (DIV_EN && dop != 0) return div_ref(dop, a, b);
        return alu_ref(aop, a, b);
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic wait_valid(input string tag, output int lat);
        lat = 0;
        while (bus.ex_to_mem_valid !== 1'b1 && lat < 100) begin
            step();
            lat++;
        end
        check({tag, "/valid"}, bus.ex_to_mem_valid, 1'b1);
    endtask

    // One instruction with mem_allowin held high, checked end to end
    task automatic run_one(input string tag, input logic [11:0] aop, input logic [31:0] a,
                           input logic [31:0] b, input logic [3:0] dop,
                           input logic rfm, input logic mwe, output logic [31:0] got_res);
        logic        rfw;
        logic [4:0]  wa;
        logic [31:0] pc, rkd, er;
        int          lat, stalls, exp_lat;
        rfw = 1'($urandom);
        wa  = 5'($urandom);
        pc  = $urandom;
        rkd = $urandom;
        er  = exp_result(aop, dop, a, b);
        exp_lat = (DIV_EN && dop != 0) ? 33 : 0;
        bus.id_to_ex_wire  = {aop, a, b, dop, rfw, wa, pc, rkd, rfm, mwe};
        bus.id_to_ex_valid = 1'b1;
        bus.mem_allowin    = 1'b1;
        step();
        bus.id_to_ex_valid = 1'b0;
        #1;
        lat = 0;
        stalls = 0;
        while (bus.ex_to_mem_valid !== 1'b1 && lat < 100) begin
            if (bus.ex_rf_zip[38]) stalls++;
            step();
            lat++;
        end
        check({tag, "/latency"}, 128'(lat), 128'(exp_lat));
        check({tag, "/stall_cycles"}, 128'(stalls), 128'(exp_lat));
        check({tag, "/to_mem"}, bus.ex_to_mem_wire, {rfw, wa, pc, er, rkd, rfm, mwe});
        check({tag, "/rf_zip"}, bus.ex_rf_zip, {rfm, rfw, wa, er});
        check({tag, "/sram"},
              {bus.data_sram_en, bus.data_sram_we, bus.data_sram_addr, bus.data_sram_wdata},
              {rfm | mwe, {4{mwe}}, er, rkd});
        got_res = bus.ex_to_mem_wire[65:34];
        step();
        check({tag, "/drained"}, bus.ex_to_mem_valid, 1'b0);
    endtask

    initial begin
        logic [31:0] r, r2, er;
        logic [11:0] aop;
        logic [3:0]  dop;
        logic        rfm, mwe;
        int          lat, t1, t2, k, m;

        resetn             = 1'b0;
        bus.id_to_ex_valid = 1'b0;
        bus.id_to_ex_wire  = '0;
        bus.mem_allowin    = 1'b1;
        step();
        step();
        check("reset/allowin", bus.ex_allowin, 1'b1);
        check("reset/outputs",
              {bus.ex_to_mem_valid, bus.data_sram_en, bus.data_sram_we, bus.ex_rf_zip[38:37]}, '0);
        resetn = 1'b1;

        // add.w 5 + 7
        run_one("add", 12'h001, 32'd5, 32'd7, 4'b0000, 1'b0, 1'b0, r);
        check("add/lit", r, 32'd12);

        // divider directed cases
        run_one("div_w", 12'h000, 32'hFFFF_FFF9, 32'd2, 4'b1000, 1'b0, 1'b0, r);
        run_one("mod_w", 12'h000, 32'hFFFF_FFF9, 32'd2, 4'b0100, 1'b0, 1'b0, r2);
`ifdef EX_DIV_EN
        check("div_w/lit", r, 32'hFFFF_FFFD);
        check("mod_w/lit", r2, 32'hFFFF_FFFF);
`endif
        run_one("div_wu", 12'h000, 32'hFFFF_FFFF, 32'h10, 4'b0010, 1'b0, 1'b0, r);
        run_one("mod_wu0", 12'h000, 32'd5, 32'd0, 4'b0001, 1'b0, 1'b0, r2);
`ifdef EX_DIV_EN
        check("div_wu/lit", r, 32'h0FFF_FFFF);
        check("mod_wu0/lit", r2, 32'd5);
`endif
        run_one("div_ovf", 12'h000, 32'h8000_0000, 32'hFFFF_FFFF, 4'b1000, 1'b0, 1'b0, r);
`ifdef EX_DIV_EN
        check("div_ovf/lit", r, 32'h8000_0000);
`endif

        // store held by mem_allowin=0 for 3 cycles: one SRAM pulse on release
        bus.id_to_ex_wire  = {12'h001, 32'h10, 32'hC, 4'b0000, 1'b0, 5'd0, 32'h1C00_0000,
                              32'hA5A5_A5A5, 1'b0, 1'b1};
        bus.id_to_ex_valid = 1'b1;
        bus.mem_allowin    = 1'b0;
        step();
        bus.id_to_ex_valid = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            check("store_hold/valid", bus.ex_to_mem_valid, 1'b1);
            check("store_hold/en", bus.data_sram_en, 1'b0);
            step();
        end
        bus.mem_allowin = 1'b1;
        #1;
        check("store_rel/sram",
              {bus.data_sram_en, bus.data_sram_we, bus.data_sram_addr, bus.data_sram_wdata},
              {1'b1, 4'hF, 32'h1C, 32'hA5A5_A5A5});
        step();
        check("store_after/en", bus.data_sram_en, 1'b0);

        // divide finished while memory stalls: result must hold
        er = exp_result(12'h002, 4'b0010, 32'd100, 32'd7);
        bus.id_to_ex_wire  = {12'h002, 32'd100, 32'd7, 4'b0010, 1'b1, 5'd3, 32'h0, 32'h0, 1'b0, 1'b0};
        bus.id_to_ex_valid = 1'b1;
        bus.mem_allowin    = 1'b0;
        step();
        bus.id_to_ex_valid = 1'b0;
        #1;
        wait_valid("div_hold", lat);
        for (int i = 0; i < 3; i++) begin
            check("div_hold/result", {bus.ex_to_mem_valid, bus.ex_to_mem_wire[65:34]}, {1'b1, er});
            check("div_hold/allowin", bus.ex_allowin, 1'b0);
            step();
        end
        bus.mem_allowin = 1'b1;
        step();
        check("div_hold/drained", bus.ex_to_mem_valid, 1'b0);

        // reset in the middle of a divide
        bus.id_to_ex_wire  = {12'h000, 32'hFFFF_FFF9, 32'd2, 4'b1000, 1'b1, 5'd9, 32'h0, 32'h0, 1'b0, 1'b0};
        bus.id_to_ex_valid = 1'b1;
        step();
        bus.id_to_ex_valid = 1'b0;
        repeat (10) step();
        resetn = 1'b0;
        step();
        check("midreset/outputs",
              {bus.ex_allowin, bus.ex_to_mem_valid, bus.data_sram_en, bus.ex_rf_zip[38:37]},
              {1'b1, 4'b0});
        resetn = 1'b1;
        run_one("post_reset_add", 12'h001, 32'd40, 32'd2, 4'b0000, 1'b0, 1'b0, r);
        check("post_reset_add/lit", r, 32'd42);

        // back-to-back mod.w: second result 34 cycles after the first
        bus.mem_allowin    = 1'b1;
        bus.id_to_ex_wire  = {12'h000, 32'hFFFF_FFF9, 32'd2, 4'b0100, 1'b1, 5'd1, 32'h0, 32'h0, 1'b0, 1'b0};
        bus.id_to_ex_valid = 1'b1;
        step();
        bus.id_to_ex_wire  = {12'h000, 32'd100, 32'hFFFF_FFF7, 4'b0100, 1'b1, 5'd2, 32'h0, 32'h0, 1'b0, 1'b0};
        #1;
        wait_valid("b2b_first", lat);
        t1 = cyc;
        check("b2b_first/result", bus.ex_to_mem_wire[65:34],
              exp_result(12'h000, 4'b0100, 32'hFFFF_FFF9, 32'd2));
        step();
        bus.id_to_ex_valid = 1'b0;
        #1;
        wait_valid("b2b_second", lat);
        t2 = cyc;
        check("b2b/spacing", 128'(t2 - t1), DIV_EN ? 128'd34 : 128'd1);
        check("b2b_second/result", bus.ex_to_mem_wire[65:34],
              exp_result(12'h000, 4'b0100, 32'd100, 32'hFFFF_FFF7));
        step();

        // randomized mix of ALU, load/store and divide instructions
        for (int n = 0; n < 40; n++) begin
            k = $urandom_range(0, 15);
            rfm = 1'b0;
            mwe = 1'b0;
            if (k < 12) begin
                aop = 12'(1 << k);
                dop = 4'b0000;
                m = $urandom_range(0, 2);
                rfm = (m == 1);
                mwe = (m == 2);
            end else begin
                aop = 12'(1 << $urandom_range(0, 11));
                dop = 4'(1 << (k - 12));
            end
            run_one("rand", aop, pick_operand(), pick_operand(), dop, rfm, mwe, r);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
